// File: rtl/pip_issue_queue.sv
// Issue buffer in front of the pipelined processor: a small FIFO of
// (instr, a, b) triples feeding a registered output stage that emits NOP bubbles.
module pip_issue_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_instr,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          stall,
    output logic [W-1:0]  instr,
    output logic [W-1:0]  data_a,
    output logic [W-1:0]  data_b,
    output logic          issue_valid,
    output logic [CW-1:0] count,
    output logic          illegal_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem_instr [DEPTH];
    logic [W-1:0]  mem_a     [DEPTH];
    logic [W-1:0]  mem_b     [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          push;
    logic          pop;
    logic          illegal_in;

    // Full FIFO never accepts, even if the head leaves this same cycle.
    assign in_ready   = !reset && (count != FULL);
    assign push       = in_valid && in_ready;
    assign pop        = !stall && (count != '0);
    assign illegal_in = in_instr > W'(2);

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= illegal_in ? '0 : in_instr;
            mem_a[wptr]     <= in_a;
            mem_b[wptr]     <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            instr        <= '0;
            data_a       <= '0;
            data_b       <= '0;
            issue_valid  <= 1'b0;
            illegal_seen <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && illegal_in)
                illegal_seen <= 1'b1;
            // pop is gated on registered count, so a push into an empty FIFO
            // always lands in storage first and issues on the next free edge.
            if (!stall) begin
                if (pop) begin
                    instr       <= mem_instr[rptr];
                    data_a      <= mem_a[rptr];
                    data_b      <= mem_b[rptr];
                    issue_valid <= 1'b1;
                end else begin
                    instr       <= '0;
                    data_a      <= '0;
                    data_b      <= '0;
                    issue_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pip_issue_queue.sv
// Bench for pip_issue_queue: directed vector table plus a queue-based
// reference model checked every cycle, including a random traffic phase.
module tb_pip_issue_queue;

    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_instr, in_a, in_b;
    logic          stall;
    logic [W-1:0]  instr, data_a, data_b;
    logic          issue_valid;
    logic [CW-1:0] count;
    logic          illegal_seen;

    int checks = 0;
    int errors = 0;

    pip_issue_queue #(.DEPTH(DEPTH), .W(W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_a(in_a), .in_b(in_b), .stall(stall),
        .instr(instr), .data_a(data_a), .data_b(data_b),
        .issue_valid(issue_valid), .count(count), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (scoreboard queue) ----------------
    typedef struct packed {
        logic [W-1:0] i;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } trip_t;

    trip_t        mq[$];
    logic         m_iv = 1'b0;
    logic [W-1:0] m_i = '0, m_a = '0, m_b = '0;
    logic         m_ill = 1'b0;

    always @(posedge clk) begin
        trip_t t;
        logic  do_pop, do_push;
        if (reset) begin
            mq.delete();
            m_iv = 1'b0; m_i = '0; m_a = '0; m_b = '0; m_ill = 1'b0;
        end else begin
            do_pop  = !stall && (mq.size() > 0);
            do_push = in_valid && (mq.size() != DEPTH);
            if (!stall) begin
                if (do_pop) begin
                    t = mq.pop_front();
                    m_iv = 1'b1; m_i = t.i; m_a = t.a; m_b = t.b;
                end else begin
                    m_iv = 1'b0; m_i = '0; m_a = '0; m_b = '0;
                end
            end
            if (do_push) begin
                t.i = (in_instr > 8'd2) ? 8'd0 : in_instr;
                t.a = in_a;
                t.b = in_b;
                mq.push_back(t);
                if (in_instr > 8'd2) m_ill = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [3*W+CW+2:0] got, exp;
        logic              m_rdy;
        m_rdy = !reset && (mq.size() != DEPTH);
        got = {issue_valid, instr, data_a, data_b, count, in_ready, illegal_seen};
        exp = {m_iv, m_i, m_a, m_b, CW'(mq.size()), m_rdy, m_ill};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model t=%0t got iv=%b i=%0d a=%0d b=%0d cnt=%0d rdy=%b ill=%b exp iv=%b i=%0d a=%0d b=%0d cnt=%0d rdy=%b ill=%b",
                     $time, issue_valid, instr, data_a, data_b, count, in_ready, illegal_seen,
                     m_iv, m_i, m_a, m_b, mq.size(), m_rdy, m_ill);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic         rst, vld, stl;
        logic [W-1:0] ins, a, b;
        logic         e_iv;
        logic [W-1:0] e_i, e_a, e_b;
        int           e_cnt;
        logic         e_rdy, e_ill;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(logic rst, logic vld, logic stl, int ins, int a, int b,
                                logic e_iv, int e_i, int e_a, int e_b, int e_cnt,
                                logic e_rdy, logic e_ill);
        vec_t v;
        v.rst = rst; v.vld = vld; v.stl = stl;
        v.ins = W'(ins); v.a = W'(a); v.b = W'(b);
        v.e_iv = e_iv; v.e_i = W'(e_i); v.e_a = W'(e_a); v.e_b = W'(e_b);
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ill = e_ill;
        return v;
    endfunction

    initial begin
        // Expectations are the state seen after the edge, inputs still applied.
        // reset, then idle 5
        vec.push_back(mk(1,0,0, 0,0,0,     0,0,0,0, 0,0,0));
        for (int k = 0; k < 5; k++)
            vec.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,1,0));
        // single ADD: latency 1 then bubble
        vec.push_back(mk(0,1,0, 1,32,12,   0,0,0,0,    1,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     1,1,32,12,  0,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     0,0,0,0,    0,1,0));
        // back-to-back ADD, SUB, NOP
        vec.push_back(mk(0,1,0, 1,32,12,   0,0,0,0,    1,1,0));
        vec.push_back(mk(0,1,0, 2,32,12,   1,1,32,12,  1,1,0));
        vec.push_back(mk(0,1,0, 0,0,0,     1,2,32,12,  1,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     1,0,0,0,    0,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     0,0,0,0,    0,1,0));
        // stalled fill to full, 5th held, then drain with wrap
        vec.push_back(mk(0,1,1, 1,10,1,    0,0,0,0,    1,1,0));
        vec.push_back(mk(0,1,1, 2,11,2,    0,0,0,0,    2,1,0));
        vec.push_back(mk(0,1,1, 1,12,3,    0,0,0,0,    3,1,0));
        vec.push_back(mk(0,1,1, 2,13,4,    0,0,0,0,    4,0,0));
        vec.push_back(mk(0,1,1, 1,14,5,    0,0,0,0,    4,0,0));
        vec.push_back(mk(0,1,0, 1,14,5,    1,1,10,1,   3,1,0));
        vec.push_back(mk(0,1,0, 1,14,5,    1,2,11,2,   3,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     1,1,12,3,   2,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     1,2,13,4,   1,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     1,1,14,5,   0,1,0));
        vec.push_back(mk(0,0,0, 0,0,0,     0,0,0,0,    0,1,0));
        // illegal opcode sanitised, sticky flag
        vec.push_back(mk(0,1,0, 255,7,9,   0,0,0,0,    1,1,1));
        vec.push_back(mk(0,0,0, 0,0,0,     1,0,7,9,    0,1,1));
        vec.push_back(mk(0,0,0, 0,0,0,     0,0,0,0,    0,1,1));
        // fill to 3, reset mid-stream, no stale issue afterwards
        vec.push_back(mk(0,1,1, 1,33,34,   0,0,0,0,    1,1,1));
        vec.push_back(mk(0,1,1, 2,35,36,   0,0,0,0,    2,1,1));
        vec.push_back(mk(0,1,1, 1,37,38,   0,0,0,0,    3,1,1));
        vec.push_back(mk(1,1,0, 1,39,40,   0,0,0,0,    0,0,0));
        for (int k = 0; k < 4; k++)
            vec.push_back(mk(0,0,0, 0,0,0, 0,0,0,0, 0,1,0));

        for (int n = 0; n < vec.size(); n++) begin
            reset    = vec[n].rst;
            in_valid = vec[n].vld;
            stall    = vec[n].stl;
            in_instr = vec[n].ins;
            in_a     = vec[n].a;
            in_b     = vec[n].b;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (issue_valid !== vec[n].e_iv || instr !== vec[n].e_i ||
                data_a !== vec[n].e_a || data_b !== vec[n].e_b ||
                count !== CW'(vec[n].e_cnt) || in_ready !== vec[n].e_rdy ||
                illegal_seen !== vec[n].e_ill) begin
                errors++;
                $display("FAIL row %0d got iv=%b i=%0d a=%0d b=%0d cnt=%0d rdy=%b ill=%b exp iv=%b i=%0d a=%0d b=%0d cnt=%0d rdy=%b ill=%b",
                         n, issue_valid, instr, data_a, data_b, count, in_ready, illegal_seen,
                         vec[n].e_iv, vec[n].e_i, vec[n].e_a, vec[n].e_b, vec[n].e_cnt,
                         vec[n].e_rdy, vec[n].e_ill);
            end
        end

        // random traffic against the reference model, occasional reset
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            stall    = ($urandom_range(0, 3) == 0);
            in_instr = ($urandom_range(0, 15) == 0) ? W'($urandom_range(3, 255))
                                                    : W'($urandom_range(0, 2));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0; in_valid = 1'b0; stall = 1'b0;
        repeat (DEPTH + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
